// File: rtl/pe_operand_feeder.sv
// pe_operand_feeder: serial activations -> N_REG-wide sliding window plus serially loaded kernel, bias and slope for one PE
// Ports: clk, rst_n (async, active low); w_valid/w_ready/w_data kernel load, cfg_we/b_in/alpha_in bias+slope latch;
// in_valid/in_ready/in_data/in_last activation stream; out_valid/out_ready/out_last window handshake;
// all_a window and all_w kernel (element k at [k*WIDTH +: WIDTH], k=0 oldest), b, alpha registered operands.
// Option: define PE_FEED_ZPAD_EN for 'same' zero padding (PAD=N_REG/2, FLUSH state after each frame).
module pe_operand_feeder #(
  parameter int WIDTH  = 32,
  parameter int FBITS  = 24,
  parameter int N_REG  = 31,
  parameter int STRIDE = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [WIDTH-1:0]       w_data,
  input  logic                   cfg_we,
  input  logic [WIDTH-1:0]       b_in,
  input  logic [WIDTH-1:0]       alpha_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [N_REG*WIDTH-1:0] all_a,
  output logic [N_REG*WIDTH-1:0] all_w,
  output logic [WIDTH-1:0]       b,
  output logic [WIDTH-1:0]       alpha
);
  if (FBITS >= WIDTH || N_REG < 2 || STRIDE < 1) begin : g_param_chk
    $error("pe_operand_feeder: need FBITS < WIDTH, N_REG >= 2, STRIDE >= 1");
  end
`ifdef PE_FEED_ZPAD_EN
  localparam int PAD = N_REG / 2;
  localparam int PW  = (PAD > 1) ? $clog2(PAD) : 1;
  localparam logic [PW-1:0] PL = PW'(PAD - 1);
  typedef enum logic [1:0] {LOAD, FILL, STREAM, FLUSH} state_t;
`else
  localparam int PAD = 0;
  typedef enum logic [1:0] {LOAD, FILL, STREAM} state_t;
`endif
  localparam int CW = $clog2(N_REG + 1);
  localparam int SW = $clog2(STRIDE + 1);
  localparam logic [CW-1:0] NR = CW'(N_REG);
  localparam logic [CW-1:0] ST = CW'(PAD);
  localparam logic [SW-1:0] SL = SW'(STRIDE - 1);
  state_t state;
  logic [CW-1:0] w_cnt, fill_cnt, f_nxt;
  logic [SW-1:0] stride_cnt, s_nxt;
  logic adv, acc_w, acc_in, step, trig, emit, lst, first;
  logic [WIDTH-1:0] sh_val;
  // a pending window that the consumer has not taken freezes the whole pipeline
  assign adv      = !(out_valid && !out_ready);
  assign w_ready  = (state == LOAD && w_cnt != NR) || (state == FILL && fill_cnt == ST && !out_valid);
  // a kernel reload wins over a sample offered in the same cycle
  assign in_ready = (state == FILL || state == STREAM) && adv && !(w_valid && w_ready);
  assign acc_w    = w_valid && w_ready;
  assign acc_in   = in_valid && in_ready;
  assign sh_val   = acc_in ? in_data : '0;
  // counter advance shared by real samples and injected pad zeros
  assign f_nxt = (fill_cnt == NR) ? fill_cnt : fill_cnt + 1'b1;
  assign trig  = (fill_cnt == NR) ? (stride_cnt == SL) : (f_nxt == NR);
  assign s_nxt = (fill_cnt != NR || stride_cnt == SL) ? '0 : stride_cnt + 1'b1;
`ifdef PE_FEED_ZPAD_EN
  logic [PW-1:0] p_cnt;
  int rem;
  // does any of the next n pad zeros still complete a window?
  function automatic logic more(input logic [CW-1:0] f, input logic [SW-1:0] s, input int n);
    logic r;
    r = 1'b0;
    for (int j = 0; j < PAD; j++)
      if (j < n) begin
        if (f != NR) begin
          f = f + 1'b1;
          r = r || (f == NR);
          s = '0;
        end else begin
          r = r || (s == SL);
          s = (s == SL) ? '0 : s + 1'b1;
        end
      end
    return r;
  endfunction
  assign step  = acc_in || (state == FLUSH && adv);
  assign emit  = step && trig;
  assign rem   = acc_in ? PAD : PAD - 1 - int'(p_cnt);
  assign lst   = (acc_in ? in_last : 1'b1) && !more(f_nxt, s_nxt, rem);
  // the first sample of a frame lands in an all-zero window (left padding)
  assign first = acc_in && state == FILL && fill_cnt == ST;
`else
  assign step  = acc_in;
  // in_last on a full window forces one more (partial-stride) window
  assign emit  = step && (trig || (in_last && fill_cnt == NR));
  assign lst   = in_last;
  assign first = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= LOAD;
      w_cnt      <= '0;
      fill_cnt   <= '0;
      stride_cnt <= '0;
      all_a      <= '0;
      all_w      <= '0;
      b          <= '0;
      alpha      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
`ifdef PE_FEED_ZPAD_EN
      p_cnt      <= '0;
`endif
    end else begin
      if (acc_w) all_w <= {w_data, all_w[N_REG*WIDTH-1:WIDTH]};
      if (cfg_we && w_ready) begin
        b     <= b_in;
        alpha <= alpha_in;
      end
      if (step) all_a <= first ? {sh_val, {((N_REG-1)*WIDTH){1'b0}}} : {sh_val, all_a[N_REG*WIDTH-1:WIDTH]};
      out_valid <= emit || (out_valid && !out_ready);
      out_last  <= emit ? lst : out_last && !out_ready;
      case (state)
        LOAD:
          if (acc_w) w_cnt <= w_cnt + 1'b1;
          else if (w_cnt == NR) begin
            state      <= FILL;
            fill_cnt   <= ST;
            stride_cnt <= '0;
          end
        FILL, STREAM:
          if (acc_w) begin
            state <= LOAD;
            w_cnt <= CW'(1);
          end else if (step) begin
            fill_cnt   <= f_nxt;
            stride_cnt <= s_nxt;
            if (trig) state <= STREAM;
            if (in_last) begin
`ifdef PE_FEED_ZPAD_EN
              state <= FLUSH;
              p_cnt <= '0;
`else
              state      <= FILL;
              fill_cnt   <= '0;
              stride_cnt <= '0;
`endif
            end
          end
`ifdef PE_FEED_ZPAD_EN
        FLUSH:
          if (step) begin
            fill_cnt   <= f_nxt;
            stride_cnt <= s_nxt;
            p_cnt      <= p_cnt + 1'b1;
            if (p_cnt == PL) begin
              state      <= FILL;
              fill_cnt   <= ST;
              stride_cnt <= '0;
            end
          end
`endif
        default: state <= LOAD;
      endcase
    end
endmodule
